// File: rtl/maxpool2d_mem_if.sv
// Bundle of the maxpool engine's handshake and memory-bus signals.
// The engine connects through the master modport; the memory/control side through the slave modport.
interface maxpool2d_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic                  done;
  logic                  valid;
  logic [ADDR_WIDTH-1:0] input_addr;
  logic [DATA_WIDTH-1:0] input_data;
  logic                  input_en;
  logic [ADDR_WIDTH-1:0] output_addr;
  logic [DATA_WIDTH-1:0] output_data;
  logic                  output_we;
  logic                  output_en;

  modport master (
    input  start, input_data,
    output done, valid, input_addr, input_en, output_addr, output_data, output_we, output_en
  );

  modport slave (
    output start, input_data,
    input  done, valid, input_addr, input_en, output_addr, output_data, output_we, output_en
  );
endinterface

// File: rtl/maxpool2d_mem.sv
// 2-D max pooling over an NCHW tensor held in memory: reads K*K elements per window
// one per cycle, keeps a signed running max, writes one result per window.
module maxpool2d_mem #(
  parameter int BATCH_SIZE = 1,
  parameter int CHANNELS   = 2,
  parameter int IN_HEIGHT  = 4,
  parameter int IN_WIDTH   = 4,
  parameter int POOL_SIZE  = 2,
  parameter int STRIDE     = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  maxpool2d_mem_if.master  bus
);
  localparam int OUT_HEIGHT = (IN_HEIGHT - POOL_SIZE) / STRIDE + 1;
  localparam int OUT_WIDTH  = (IN_WIDTH - POOL_SIZE) / STRIDE + 1;
  localparam int AW         = ADDR_WIDTH;

  localparam logic [AW-1:0] ZERO_A   = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_A    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] K_LAST   = AW'(POOL_SIZE - 1);
  localparam logic [AW-1:0] OH_LAST  = AW'(OUT_HEIGHT - 1);
  localparam logic [AW-1:0] OW_LAST  = AW'(OUT_WIDTH - 1);
  localparam logic [AW-1:0] C_LAST   = AW'(CHANNELS - 1);
  localparam logic [AW-1:0] B_LAST   = AW'(BATCH_SIZE - 1);
  localparam logic [AW-1:0] STRIDE_A = AW'(STRIDE);
  localparam logic [AW-1:0] CH_A     = AW'(CHANNELS);
  localparam logic [AW-1:0] IH_A     = AW'(IN_HEIGHT);
  localparam logic [AW-1:0] IW_A     = AW'(IN_WIDTH);
  localparam logic [AW-1:0] OH_A     = AW'(OUT_HEIGHT);
  localparam logic [AW-1:0] OW_A     = AW'(OUT_WIDTH);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    INIT_WINDOW  = 3'd1,
    READ_INPUT   = 3'd2,
    WRITE_OUTPUT = 3'd3,
    DONE         = 3'd4
  } state_t;

  state_t                        state_r, state_s;
  logic [AW-1:0]                 b_r, c_r, orow_r, ocol_r, kr_r, kc_r;
  logic signed [DATA_WIDTH-1:0]  max_r;
  logic [AW-1:0]                 plane_s, in_row_s, in_col_s, in_addr_s, out_addr_s;
  logic                          last_k_s, last_win_s;

  // Window geometry and NCHW address arithmetic for the current indices.
  assign plane_s    = b_r * CH_A + c_r;
  assign in_row_s   = orow_r * STRIDE_A + kr_r;
  assign in_col_s   = ocol_r * STRIDE_A + kc_r;
  assign in_addr_s  = (plane_s * IH_A + in_row_s) * IW_A + in_col_s;
  assign out_addr_s = (plane_s * OH_A + orow_r) * OW_A + ocol_r;
  assign last_k_s   = (kr_r == K_LAST) && (kc_r == K_LAST);
  assign last_win_s = (ocol_r == OW_LAST) && (orow_r == OH_LAST) &&
                      (c_r == C_LAST) && (b_r == B_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and state-decoded bus outputs.
  always_comb begin
    state_s         = state_r;
    bus.done        = 1'b0;
    bus.valid       = 1'b0;
    bus.input_en    = 1'b0;
    bus.input_addr  = ZERO_A;
    bus.output_en   = 1'b0;
    bus.output_we   = 1'b0;
    bus.output_addr = ZERO_A;
    bus.output_data = {DATA_WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = INIT_WINDOW;
        end else begin
          state_s = IDLE;
        end
      end
      INIT_WINDOW: state_s = READ_INPUT;
      READ_INPUT: begin
        bus.input_en   = 1'b1;
        bus.input_addr = in_addr_s;
        if (last_k_s) begin
          state_s = WRITE_OUTPUT;
        end else begin
          state_s = READ_INPUT;
        end
      end
      WRITE_OUTPUT: begin
        bus.output_en   = 1'b1;
        bus.output_we   = 1'b1;
        bus.valid       = 1'b1;
        bus.output_addr = out_addr_s;
        bus.output_data = max_r;
        if (last_win_s) begin
          state_s = DONE;
        end else begin
          state_s = INIT_WINDOW;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_s  = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Window/kernel counters and running max; first element of a window loads unconditionally.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_r    <= ZERO_A;
      c_r    <= ZERO_A;
      orow_r <= ZERO_A;
      ocol_r <= ZERO_A;
      kr_r   <= ZERO_A;
      kc_r   <= ZERO_A;
      max_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            b_r    <= ZERO_A;
            c_r    <= ZERO_A;
            orow_r <= ZERO_A;
            ocol_r <= ZERO_A;
          end
        end
        INIT_WINDOW: begin
          kr_r <= ZERO_A;
          kc_r <= ZERO_A;
        end
        READ_INPUT: begin
          if ((kr_r == ZERO_A) && (kc_r == ZERO_A)) begin
            max_r <= bus.input_data;
          end else if ($signed(bus.input_data) > max_r) begin
            max_r <= bus.input_data;
          end
          if (kc_r == K_LAST) begin
            kc_r <= ZERO_A;
            kr_r <= kr_r + ONE_A;
          end else begin
            kc_r <= kc_r + ONE_A;
          end
        end
        WRITE_OUTPUT: begin
          if (ocol_r != OW_LAST) begin
            ocol_r <= ocol_r + ONE_A;
          end else begin
            ocol_r <= ZERO_A;
            if (orow_r != OH_LAST) begin
              orow_r <= orow_r + ONE_A;
            end else begin
              orow_r <= ZERO_A;
              if (c_r != C_LAST) begin
                c_r <= c_r + ONE_A;
              end else begin
                c_r <= ZERO_A;
                b_r <= (b_r != B_LAST) ? b_r + ONE_A : ZERO_A;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_maxpool2d_mem.sv
// Randomised and directed bench for maxpool2d_mem: a default 2x2/stride-2 instance and a
// 3x3/stride-1 instance share one input memory and are compared against a plain max-over-window model.
module tb_maxpool2d_mem;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maxpool2d_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) ifa ();
  maxpool2d_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) ifb ();

  maxpool2d_mem dut_a (.clk(clk), .rst(rst), .bus(ifa));
  maxpool2d_mem #(.POOL_SIZE(3), .STRIDE(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [31:0] in_mem [32];
  logic [31:0] out_a [8];
  logic [31:0] out_b [8];
  logic [31:0] exp_mem [8];
  int checks = 0;
  int errors = 0;
  int wr_a = 0, wr_b = 0, val_a = 0, val_b = 0, done_a = 0, done_b = 0, vmis = 0, oob = 0;

  assign ifa.input_data = in_mem[ifa.input_addr[4:0]];
  assign ifb.input_data = in_mem[ifb.input_addr[4:0]];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: max over each KxK window, NCHW, 1 batch, 2 channels, 4x4 input.
  task automatic ref_pool(input int k, input int s);
    int oh;
    logic signed [31:0] m, v;
    oh = (4 - k) / s + 1;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < oh; r++)
        for (int q = 0; q < oh; q++) begin
          m = in_mem[(c * 4 + r * s) * 4 + q * s];
          for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++) begin
              v = in_mem[(c * 4 + r * s + i) * 4 + q * s + j];
              if (v > m) m = v;
            end
          exp_mem[(c * oh + r) * oh + q] = m;
        end
  endtask

  // Advance to the next negative edge and record every bus event of both engines.
  task automatic tick();
    @(negedge clk);
    if (ifa.output_we) begin
      if (ifa.output_addr < 16'd8) out_a[ifa.output_addr[2:0]] = ifa.output_data;
      else oob++;
      wr_a++;
    end
    if (ifb.output_we) begin
      if (ifb.output_addr < 16'd8) out_b[ifb.output_addr[2:0]] = ifb.output_data;
      else oob++;
      wr_b++;
    end
    if (ifa.valid) val_a++;
    if (ifb.valid) val_b++;
    if (ifa.done) done_a++;
    if (ifb.done) done_b++;
    if (ifa.valid !== ifa.output_we || ifa.output_en !== ifa.output_we) vmis++;
    if (ifb.valid !== ifb.output_we || ifb.output_en !== ifb.output_we) vmis++;
  endtask

  task automatic clear_out();
    for (int i = 0; i < 8; i++) begin
      out_a[i] = 32'hDEADBEEF;
      out_b[i] = 32'hDEADBEEF;
    end
  endtask

  task automatic run_job(input int sel, input bit hold);
    int n, kk, w0, v0, d0, m0, o0;
    bit seen;
    clear_out();
    kk = (sel == 0) ? 4 : 9;
    if (sel == 0) ref_pool(2, 2);
    else ref_pool(3, 1);
    w0 = (sel == 0) ? wr_a : wr_b;
    v0 = (sel == 0) ? val_a : val_b;
    d0 = (sel == 0) ? done_a : done_b;
    m0 = vmis;
    o0 = oob;
    if (sel == 0) ifa.start = 1'b1;
    else ifb.start = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      tick();
      n++;
      if (n == 1 && !hold) begin
        ifa.start = 1'b0;
        ifb.start = 1'b0;
      end
      if ((sel == 0 && ifa.done) || (sel == 1 && ifb.done)) seen = 1'b1;
    end
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    check_val("done_cycle", n, 8 * (kk + 2) + 1);
    tick();
    check_val("done_one_cycle", (sel == 0) ? ifa.done : ifb.done, 32'd0);
    repeat (3) tick();
    check_val("writes", ((sel == 0) ? wr_a : wr_b) - w0, 32'd8);
    check_val("valid_pulses", ((sel == 0) ? val_a : val_b) - v0, 32'd8);
    check_val("done_pulses", ((sel == 0) ? done_a : done_b) - d0, 32'd1);
    check_val("valid_we_en_align", vmis - m0, 32'd0);
    check_val("write_out_of_range", oob - o0, 32'd0);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("out%0d[%0d]", sel, i), (sel == 0) ? out_a[i] : out_b[i], exp_mem[i]);
  endtask

  task automatic fill_ramp(input bit neg);
    for (int i = 0; i < 32; i++) in_mem[i] = neg ? -i : i;
  endtask

  initial begin
    int w0, d0;
    logic [31:0] corner [4];
    rst = 1'b1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    fill_ramp(1'b0);
    clear_out();
    tick();
    tick();
    check_val("rst_done", ifa.done, 32'd0);
    check_val("rst_valid", ifa.valid, 32'd0);
    check_val("rst_input_en", ifa.input_en, 32'd0);
    check_val("rst_output_we", ifa.output_we, 32'd0);
    check_val("rst_input_addr", ifa.input_addr, 32'd0);
    check_val("rst_output_data", ifa.output_data, 32'd0);
    rst = 1'b0;
    tick();

    // Ascending and descending ramps on the default engine.
    fill_ramp(1'b0);
    run_job(0, 1'b0);
    check_val("ramp_out3", out_a[3], 32'd15);
    fill_ramp(1'b1);
    run_job(0, 1'b0);
    check_val("negramp_out1", out_a[1], -32'sd2);

    // Extreme signed values in window 0.
    for (int i = 0; i < 32; i++) in_mem[i] = 32'd0;
    in_mem[0] = 32'h80000000;
    in_mem[1] = 32'hFFFFFFFF;
    in_mem[4] = 32'd1;
    in_mem[5] = 32'd0;
    run_job(0, 1'b0);
    check_val("extreme_out0", out_a[0], 32'd1);

    // Reset inside the third window's read phase.
    fill_ramp(1'b0);
    clear_out();
    w0 = wr_a;
    d0 = done_a;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    repeat (14) tick();
    check_val("pre_rst_reading", ifa.input_en, 32'd1);
    rst = 1'b1;
    tick();
    check_val("mid_rst_input_en", ifa.input_en, 32'd0);
    check_val("mid_rst_input_addr", ifa.input_addr, 32'd0);
    check_val("mid_rst_output_we", ifa.output_we, 32'd0);
    check_val("mid_rst_output_en", ifa.output_en, 32'd0);
    check_val("mid_rst_valid", ifa.valid, 32'd0);
    check_val("mid_rst_done", ifa.done, 32'd0);
    check_val("mid_rst_output_addr", ifa.output_addr, 32'd0);
    check_val("mid_rst_output_data", ifa.output_data, 32'd0);
    rst = 1'b0;
    repeat (60) tick();
    check_val("aborted_writes", wr_a - w0, 32'd2);
    check_val("aborted_done", done_a - d0, 32'd0);
    check_val("aborted_out0", out_a[0], 32'd5);
    check_val("aborted_out1", out_a[1], 32'd7);
    check_val("aborted_out2", out_a[2], 32'hDEADBEEF);
    run_job(0, 1'b0);

    // Start held through the whole job launches exactly one job.
    run_job(0, 1'b1);

    // 3x3 stride-1 engine on the ramp.
    fill_ramp(1'b0);
    run_job(1, 1'b0);
    check_val("k3_out0", out_b[0], 32'd10);

    // Randomised contents, biased towards signed extremes.
    corner[0] = 32'h80000000;
    corner[1] = 32'h7FFFFFFF;
    corner[2] = 32'hFFFFFFFF;
    corner[3] = 32'h00000000;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 32; i++) begin
        if ($urandom_range(0, 3) == 0) in_mem[i] = corner[$urandom_range(0, 3)];
        else in_mem[i] = $urandom;
      end
      run_job(it % 2, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/maxpool2d_mem.md
MAXPOOL2D_MEM -- requirements
Module: maxpool2d_mem

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- BATCH_SIZE, 1, batch count.
- CHANNELS, 2, channel count, which is equal at input and output.
- IN_HEIGHT, 4, input rows.
- IN_WIDTH, 4, input columns.
- POOL_SIZE, 2, square window edge K.
- STRIDE, 2, window step S.
- DATA_WIDTH, 32, signed element width.
- ADDR_WIDTH, 16, memory address width.
REQ-002 Derived values: OUT_HEIGHT=(IN_HEIGHT-K)/S+1; OUT_WIDTH=(IN_WIDTH-K)/S+1; N_OUT=BATCH_SIZE*CHANNELS*OUT_HEIGHT*OUT_WIDTH.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- start, in, 1, begin job.
- done, out, 1, job complete.
- valid, out, 1, result written this cycle.
- input_addr, out, ADDR_WIDTH, read address into the conv output memory.
- input_data, in, DATA_WIDTH, read data; combinational, valid in the same cycle as input_addr/input_en.
- input_en, out, 1, read enable.
- output_addr, out, ADDR_WIDTH, write address.
- output_data, out, DATA_WIDTH, pooled value.
- output_we, out, 1, write enable.
- output_en, out, 1, memory enable.
REQ-004 Both memories shall use NCHW linear layout: addr=((b*CHANNELS+c)*H+row)*W+col, with H/W being input or output dimensions as appropriate.

Function
REQ-005 FSM states: IDLE, INIT_WINDOW, READ_INPUT, WRITE_OUTPUT, DONE.
REQ-006 IDLE: start=1 at a clock edge shall move the FSM to INIT_WINDOW with window indices (b,c,orow,ocol)=(0,0,0,0); start=0 holds IDLE.
REQ-007 INIT_WINDOW (1 cycle): kernel indices (kr,kc) shall clear to (0,0); the FSM then moves to READ_INPUT.
REQ-008 READ_INPUT (K*K cycles, one element per cycle, raster kr-major):
- input_en=1 and input_addr=addr(b,c,orow*S+kr,ocol*S+kc).
- input_data sampled at the cycle's clock edge.
REQ-009 Max update: the first element of a window (kr=kc=0) shall load the running max unconditionally; each later element replaces it only if strictly greater under two's-complement signed compare.
REQ-010 After the (K-1,K-1) read, the FSM shall enter WRITE_OUTPUT.
REQ-011 WRITE_OUTPUT (1 cycle): output_en=output_we=valid=1, output_addr=addr(b,c,orow,ocol), output_data=running max.
REQ-012 Index advance after WRITE_OUTPUT: ocol fastest, then orow, c, b.
- If more windows remain: next state INIT_WINDOW.
- After window N_OUT-1: next state DONE.
REQ-013 DONE: done=1 for exactly one cycle; the FSM then returns to IDLE.
REQ-014 Control outputs shall be state-decoded:
- input_en=1 only in READ_INPUT.
- output_en/output_we/valid=1 only in WRITE_OUTPUT.
- done=1 only in DONE.
REQ-015 start asserted in any state other than IDLE shall be ignored.
REQ-016 Latency: per window K*K+2 cycles. With start sampled at edge 0, done is high in cycle N_OUT*(K*K+2)+1.
REQ-017 All reads shall be in range by construction; no padding logic; no write to an address ≥ N_OUT.

Reset
REQ-018 rst=1 at a clock edge shall force, regardless of current state (including mid-window):
- state=IDLE.
- all indices and the running max = 0.
- done, valid, input_en, output_en, output_we = 0.
- input_addr, output_addr, output_data = 0.
REQ-019 A job interrupted by reset shall not complete or write further. A new start after reset begins at window (0,0,0,0).

Verification
REQ-020 Defaults, input_mem[i]=i (0..31), start pulsed 1 cycle -> output_mem=[5,7,13,15,21,23,29,31]; done high in cycle 49 (8 windows x 6 cycles + 1); done held one cycle only.
REQ-021 Defaults, input_mem[i]=-i -> output_mem=[0,-2,-8,-10,-16,-18,-24,-26], proving signed compare and first-element load.
REQ-022 Window 0 elements {32'h80000000, 32'hFFFFFFFF, 1, 0}, others 0 -> output_mem[0]=1; valid pulses exactly 8 times, each coincident with output_we.
REQ-023 rst asserted during the 3rd window's READ_INPUT, then released -> all outputs 0 next cycle; only output_mem[0..1] written; a restart then yields the full REQ-020 result.
REQ-024 start held high through the whole job -> exactly one job (8 writes); a re-launch occurs only from IDLE after DONE.
REQ-025 POOL_SIZE=3, STRIDE=1, input_mem[i]=i -> OUT 2x2 per channel, output_mem=[10,11,14,15,26,27,30,31]; done high in cycle 8*11+1=89.
